fifo_param: RTL

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fifo_param.sv
// fifo_param: single-clock synchronous FIFO with registered read data,
// occupancy count, almost-full/almost-empty thresholds and sticky error flags.
//
// Ports:
//   clk           rising-edge clock
//   RESET         synchronous active-high reset
//   data_in       write data
//   fifo_wr       write request
//   fifo_rd       read request
//   err_clr       clears sticky error flags
//   data_out      registered read data (holds when rd_valid = 0)
//   rd_valid      data_out carries a word popped on the previous edge
//   fifo_empty    count == 0
//   fifo_full     count == DEPTH
//   almost_empty  count <= ALMOST_EMPTY_LVL
//   almost_full   count >= ALMOST_FULL_LVL
//   count         occupancy, 0..DEPTH
//   err_overflow  sticky: write refused
//   err_underflow sticky: read refused
module fifo_param #(
  parameter int unsigned DATA_WIDTH       = 6,
  parameter int unsigned DEPTH            = 8,
  parameter int unsigned ADDR_W           = 3,
  parameter int unsigned ALMOST_FULL_LVL  = 6,
  parameter int unsigned ALMOST_EMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_wr,
  input  logic                  fifo_rd,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_W:0]       count,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(ALMOST_FULL_LVL);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(ALMOST_EMPTY_LVL);

  // Elaboration-time parameter sanity checks
  if ((DEPTH < 4) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_param: DEPTH must be a power of 2 in 4..256");
  end
  if (DEPTH != (1 << ADDR_W)) begin : g_bad_addr_w
    $error("fifo_param: ADDR_W must equal log2(DEPTH)");
  end
  if (ALMOST_EMPTY_LVL >= ALMOST_FULL_LVL) begin : g_bad_ae
    $error("fifo_param: ALMOST_EMPTY_LVL must be below ALMOST_FULL_LVL");
  end
  if (ALMOST_FULL_LVL > DEPTH) begin : g_bad_af
    $error("fifo_param: ALMOST_FULL_LVL must not exceed DEPTH");
  end

  // Storage and state
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  aempty_q, aempty_d;
  logic                  afull_q, afull_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic                  rd_acc;
  logic                  wr_acc;

  // Acceptance; a read frees a slot so a write on a full FIFO still goes in
  always_comb begin
    rd_acc = fifo_rd & ~empty_q;
    wr_acc = fifo_wr & (~full_q | rd_acc);
  end

  // Next-state for pointers, count, read port, flags and errors
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    rd_valid_d = rd_acc;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
      data_out_d = mem_q[rd_ptr_q];
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Status flags are registered copies of the decode of count
    empty_d  = (count_d == '0);
    full_d   = (count_d == DEPTH_CNT);
    aempty_d = (count_d <= AE_CNT);
    afull_d  = (count_d >= AF_CNT);

    // Sticky errors: a new event in the clearing cycle wins
    ovf_d = (ovf_q & ~err_clr) | (fifo_wr & ~wr_acc);
    udf_d = (udf_q & ~err_clr) | (fifo_rd & ~rd_acc);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      aempty_q   <= 1'b1;
      afull_q    <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      aempty_q   <= aempty_d;
      afull_q    <= afull_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage array; contents are not cleared by reset
  always_ff @(posedge clk) begin
    if (!RESET && wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out      = data_out_q;
  assign rd_valid      = rd_valid_q;
  assign fifo_empty    = empty_q;
  assign fifo_full     = full_q;
  assign almost_empty  = aempty_q;
  assign almost_full   = afull_q;
  assign count         = count_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = udf_q;

endmodule
